// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline register indices and enables flowing in
// from the datapath, stall/flush/forward controls and status flowing back.
interface hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       ResultSrcE0;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       PCSrcE;
  logic       MemReqM;
  logic       MemAckM;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       StallM;
  logic       FlushD;
  logic       FlushE;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       MemErr;
  logic [1:0] CtrlState;

  // Datapath side: supplies hazard information, consumes the controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemErr, CtrlState
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemErr, CtrlState
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Holds the pipeline flushed for BOOT_CYCLES after reset, freezes it while a
// data-memory access in M waits for its acknowledge, forces release with a
// sticky MemErr when that wait hits MEM_TIMEOUT, and resolves load-use,
// branch and Execute operand-forwarding hazards combinationally.
module hazard_ctrl #(
  parameter int BOOT_CYCLES = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_ctrl_if.slave hz
);

  // Counter widths carry one spare bit so the increment constants stay legal
  // even for the smallest parameter values.
  localparam int BW = $clog2(BOOT_CYCLES + 1) + 1;
  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [BW-1:0] BOOT_INC  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_INC  = {{(WW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    BOOT    = 2'b00,
    RUN     = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  state_t        state_r;
  logic [BW-1:0] boot_cnt_r;
  logic [WW-1:0] wait_cnt_r;
  logic          mem_err_r;

  logic timeout_s;
  logic memwait_stall_s;
  logic lw_stall_s;

  // Forward select for one Execute source: M result beats W result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard conditions derived from the current state and inputs.
  always_comb begin
    timeout_s       = (state_r == MEMWAIT) && (wait_cnt_r == WAIT_LAST);
    memwait_stall_s = hz.MemReqM && !hz.MemAckM && !timeout_s;
    lw_stall_s      = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  end

  // Sequencing FSM: boot hold, memory-wait tracking and sticky timeout error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= BOOT;
      boot_cnt_r <= {BW{1'b0}};
      wait_cnt_r <= {WW{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          if (boot_cnt_r == BOOT_LAST) begin
            state_r    <= RUN;
            boot_cnt_r <= {BW{1'b0}};
          end else begin
            boot_cnt_r <= boot_cnt_r + BOOT_INC;
          end
        end
        RUN: begin
          if (memwait_stall_s) begin
            state_r    <= MEMWAIT;
            wait_cnt_r <= WAIT_INC;
          end else begin
            state_r    <= RUN;
          end
        end
        MEMWAIT: begin
          if (hz.MemAckM || timeout_s) begin
            state_r    <= RUN;
            wait_cnt_r <= {WW{1'b0}};
            if (timeout_s) begin
              mem_err_r <= 1'b1;
            end else begin
              mem_err_r <= mem_err_r;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_INC;
          end
        end
        default: begin
          state_r    <= BOOT;
          boot_cnt_r <= {BW{1'b0}};
          wait_cnt_r <= {WW{1'b0}};
        end
      endcase
    end
  end

  // Stall/flush controls: boot hold, memory freeze, else load-use and branch.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    case (state_r)
      RUN, MEMWAIT: begin
        if (memwait_stall_s) begin
          // Whole pipe frozen; E holds, so PCSrcE stays valid for later.
          hz.StallF = 1'b1;
          hz.StallD = 1'b1;
          hz.StallE = 1'b1;
          hz.StallM = 1'b1;
          hz.FlushW = 1'b1;
        end else begin
          // StallD and FlushD may both be 1; the register lets clear win.
          hz.StallF = lw_stall_s;
          hz.StallD = lw_stall_s;
          hz.FlushD = hz.PCSrcE;
          hz.FlushE = lw_stall_s || hz.PCSrcE;
        end
      end
      default: begin
        hz.StallF = 1'b1;
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
        hz.FlushW = 1'b1;
      end
    endcase
  end

  // Execute operand forwarding, live in every state including reset.
  always_comb begin
    hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  end

  // Registered status outputs.
  always_comb begin
    hz.MemErr    = mem_err_r;
    hz.CtrlState = state_r;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the controller's rules.
module tb_hazard_ctrl;
  localparam int BOOT_CYCLES = 3;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  hazard_ctrl_if hz();

  hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  // Model: edges seen since reset, cycles the current access has been pending
  // (0 = no access outstanding), and the sticky error.
  int m_edges = 0;
  int m_pend = 0;
  bit m_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit booting();
    return m_edges < BOOT_CYCLES;
  endfunction

  function automatic bit timed_out();
    return !booting() && (m_pend == MEM_TIMEOUT - 1);
  endfunction

  function automatic bit mem_frozen();
    return !booting() && hz.MemReqM && !hz.MemAckM && !timed_out();
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,MemErr,State}
  function automatic logic [13:0] expect_now();
    logic lw;
    logic [6:0] sf;
    logic [1:0] st;
    lw = hz.ResultSrcE0 && hz.RdE != 5'd0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    if (booting()) sf = 7'b1000111;
    else if (mem_frozen()) sf = 7'b1111001;
    else sf = {lw, lw, 1'b0, 1'b0, hz.PCSrcE, lw | hz.PCSrcE, 1'b0};
    st = booting() ? 2'b00 : (m_pend != 0 ? 2'b10 : 2'b01);
    return {sf, fwd_model(hz.Rs1E), fwd_model(hz.Rs2E), m_err, st};
  endfunction

  // Model state advance.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges <= 0;
      m_pend  <= 0;
      m_err   <= 1'b0;
    end else if (booting()) begin
      m_edges <= m_edges + 1;
    end else if (m_pend != 0) begin
      if (hz.MemAckM || timed_out()) begin
        m_pend <= 0;
        if (timed_out()) m_err <= 1'b1;
      end else begin
        m_pend <= m_pend + 1;
      end
    end else if (mem_frozen()) begin
      m_pend <= 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cycle_outputs",
          {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW,
           hz.ForwardAE, hz.ForwardBE, hz.MemErr, hz.CtrlState},
          expect_now());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.ResultSrcE0 = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
  endtask

  initial begin
    int stalls;
    bit done;
    clr_in();
    reset_n = 1'b0;
    run_cmp = 1'b1;

    // Reset values.
    at_neg();
    chk("rst_stallf", hz.StallF, 1'b1);
    chk("rst_flushes", {hz.FlushD, hz.FlushE, hz.FlushW}, 3'b111);
    chk("rst_state", hz.CtrlState, 2'b00);
    chk("rst_memerr", hz.MemErr, 1'b0);

    // Boot hold lasts exactly BOOT_CYCLES edges.
    step();
    reset_n = 1'b1;
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      at_neg();
      chk("boot_stallf", hz.StallF, 1'b1);
      chk("boot_flushe", hz.FlushE, 1'b1);
      step();
    end
    at_neg();
    chk("boot_done_state", hz.CtrlState, 2'b01);
    chk("boot_done_stallf", hz.StallF, 1'b0);

    // Load-use.
    step();
    hz.ResultSrcE0 = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
    at_neg();
    chk("lu_stall_flush", {hz.StallF, hz.StallD, hz.FlushE}, 3'b111);
    step();
    hz.RdE = 5'd0;
    at_neg();
    chk("lu_x0", {hz.StallF, hz.StallD, hz.FlushE}, 3'b000);

    // Branch together with load-use.
    step();
    hz.RdE = 5'd5; hz.PCSrcE = 1'b1;
    at_neg();
    chk("br_lu", {hz.FlushD, hz.FlushE, hz.StallD}, 3'b111);

    // Forwarding priority.
    step();
    clr_in();
    hz.RdM = 5'd7; hz.RdW = 5'd7; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd7;
    at_neg();
    chk("fwd_m", hz.ForwardAE, 2'b10);
    step();
    hz.RegWriteM = 1'b0;
    at_neg();
    chk("fwd_w", hz.ForwardAE, 2'b01);
    step();
    hz.Rs1E = 5'd0;
    at_neg();
    chk("fwd_x0", hz.ForwardAE, 2'b00);

    // Memory wait, ack on the third wait cycle, branch during the freeze.
    step();
    clr_in();
    hz.MemReqM = 1'b1;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} == 5'b11111) stalls++;
      if (k == 1) chk("mw_branch_flushd", hz.FlushD, 1'b0);
      step();
      hz.PCSrcE = (k == 0);
      hz.MemAckM = (k == 2);
    end
    at_neg();
    chk("mw_stall_count", stalls, 3);
    chk("mw_ack_release", hz.StallM, 1'b0);
    chk("mw_state_wait", hz.CtrlState, 2'b10);
    step();
    clr_in();
    at_neg();
    chk("mw_state_run", hz.CtrlState, 2'b01);

    // Timeout: MEM_TIMEOUT-1 stalled cycles, one released cycle, sticky error.
    step();
    hz.MemReqM = 1'b1;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < MEM_TIMEOUT + 4 && !done; c++) begin
      at_neg();
      if (hz.StallM) begin
        stalls++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    chk("to_released", done, 1'b1);
    chk("to_stall_count", stalls, MEM_TIMEOUT - 1);
    chk("to_err_before_edge", hz.MemErr, 1'b0);
    step();
    at_neg();
    chk("to_err_set", hz.MemErr, 1'b1);
    chk("to_state_run", hz.CtrlState, 2'b01);
    chk("to_reenter_stall", hz.StallM, 1'b1);
    step();
    hz.MemAckM = 1'b1;
    at_neg();
    chk("to_reenter_ack", hz.StallM, 1'b0);
    step();
    clr_in();
    for (int i = 0; i < 4; i++) begin
      step();
      at_neg();
      chk("to_err_sticky", hz.MemErr, 1'b1);
    end

    // Reset asserted in the middle of a memory wait.
    step();
    hz.MemReqM = 1'b1;
    step();
    step();
    at_neg();
    chk("rr_in_wait", hz.CtrlState, 2'b10);
    step();
    reset_n = 1'b0;
    #1;
    chk("rr_state", hz.CtrlState, 2'b00);
    chk("rr_memerr", hz.MemErr, 1'b0);
    step();
    clr_in();
    step();
    reset_n = 1'b1;

    // Randomized traffic; the per-cycle compare checks every output.
    for (int n = 0; n < 3000; n++) begin
      step();
      hz.Rs1D = 5'($urandom_range(0, 3));
      hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3));
      hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE = 5'($urandom_range(0, 3));
      hz.RdM = 5'($urandom_range(0, 3));
      hz.RdW = 5'($urandom_range(0, 3));
      hz.ResultSrcE0 = 1'($urandom_range(0, 1));
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.PCSrcE = ($urandom_range(0, 3) == 0);
      hz.MemReqM = ($urandom_range(0, 2) != 0);
      hz.MemAckM = ($urandom_range(0, 4) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
    end

    step();
    reset_n = 1'b1;
    at_neg();
    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I datapath. It produces the stall and flush controls for the F/D, D/E, E/M and M/W pipeline registers, and the operand-forwarding selects for the Execute stage. Its internal state machine does three things: holds the pipeline in bubbles after reset, freezes it while a data-memory access in M waits for acknowledge, and forces release with a sticky error if that wait times out.

## Interface
Parameters:
- BOOT_CYCLES, 3: cycles after reset release during which the pipeline is held flushed (≥1).
- MEM_TIMEOUT, 16: maximum cycles a data-memory access may wait for MemAckM (≥2).

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source register indices in Decode.
- Rs1E, Rs2E  in  5  source register indices in Execute.
- RdE, RdM, RdW  in  5  destination indices in Execute, Memory and Writeback.
- ResultSrcE0  in  1  instruction in Execute is a load.
- RegWriteM, RegWriteW  in  1  register write enables in Memory and Writeback.
- PCSrcE  in  1  branch or jump taken, resolved in Execute.
- MemReqM  in  1  instruction in Memory performs a data-memory access.
- MemAckM  in  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  synchronously clear the corresponding pipeline register.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 from W result, 10 from M ALU result.
- MemErr  out  1  sticky flag: a memory-wait timeout occurred.
- CtrlState  out  2  current FSM state, for debug.

## Operation
FSM states and encodings: BOOT=00, RUN=01, MEMWAIT=10. Two counters: boot_cnt and wait_cnt.

- **Reset (reset_n=0):** state=BOOT, boot_cnt=0, wait_cnt=0, MemErr=0.
- **BOOT:**
  - StallF=1, FlushD=FlushE=FlushW=1; StallD, StallE, StallM = 0.
  - boot_cnt increments each cycle.
  - When boot_cnt == BOOT_CYCLES-1, go to RUN and clear boot_cnt.
  - All other inputs are ignored except the forwarding logic.
- **memwait_stall** = MemReqM & ~MemAckM & ~timeout.
  - timeout = (state==MEMWAIT) & (wait_cnt == MEM_TIMEOUT-1).
- **RUN → MEMWAIT** when memwait_stall=1; wait_cnt is loaded with 1.
- **MEMWAIT:**
  - Go to RUN on MemAckM=1 or on timeout; wait_cnt clears.
  - Otherwise wait_cnt increments.
  - On timeout, MemErr is set at that edge and stays 1 until reset.
- **While memwait_stall=1 (RUN or MEMWAIT):**
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - The stall overrides both load-use and branch handling. PCSrcE is held valid because E is frozen.
- **Otherwise, in RUN or MEMWAIT:**
  - lwStall = ResultSrcE0 & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushW = 0.
  - If StallD and FlushD are both 1, the downstream register gives the clear priority; the block outputs both unchanged.
- **Forwarding** is purely combinational and active in every state:
  - ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW≠0 & RdW==Rs1E;
  - else 00.
  - ForwardBE follows the same rule with Rs2E.
  - M has priority over W.

## Timing
- All stall, flush and forward outputs are combinational from the current state, the counters and the inputs in the same cycle. There is zero-cycle latency from hazard to control.
- MemErr and CtrlState are registered, so they update one edge after the triggering condition.
- Output values while reset_n=0:
  - StallF=1, FlushD=FlushE=FlushW=1.
  - StallD=StallE=StallM=0.
  - MemErr=0, CtrlState=00.
  - ForwardAE and ForwardBE follow their inputs.
- BOOT lasts exactly BOOT_CYCLES rising edges after reset_n rises. The first RUN cycle is edge BOOT_CYCLES.
- Access with MemAckM=1 in the same cycle as MemReqM: no stall, no state change.
- Access with MemAckM=0 in the first cycle and MemAckM=1 on wait cycle k (k < MEM_TIMEOUT): stall for exactly k cycles. On the ack cycle the stall is 0 and the next state is RUN.
- No ack: stall for MEM_TIMEOUT-1 cycles, then one released cycle. MemErr=1 and state=RUN after that edge.
- reset_n asserted mid-MEMWAIT: immediate return to BOOT, counters cleared, MemErr cleared.
- A new MemReqM arriving on the cycle immediately after a release re-enters MEMWAIT normally.

## Test plan
1. **Boot.** Deassert reset_n with BOOT_CYCLES=3 → StallF and FlushE stay 1 for 3 cycles, then CtrlState=01 and StallF=0.
2. **Load-use.** ResultSrcE0=1, RdE=5, Rs1D=5 → StallF=StallD=FlushE=1. With RdE=0 → all 0.
3. **Branch under load-use.** PCSrcE=1 together with the load-use condition → FlushD=1, FlushE=1, StallD=1.
4. **Forwarding.** RdM=RdW=7, both RegWrite=1, Rs1E=7 → ForwardAE=10. With RegWriteM=0 → 01. With Rs1E=0 → 00.
5. **Memory wait.** MemReqM=1 with ack arriving on the 3rd wait cycle → all four stalls and FlushW=1 for exactly 3 cycles, then RUN. A branch asserted during the wait gives FlushD=0.
6. **Timeout and reset.** MemReqM=1 with no ack, MEM_TIMEOUT=16 → stall for 15 cycles, release, MemErr=1 sticky. Then assert reset_n=0 mid-wait in a second run → CtrlState=00 and MemErr=0 immediately.
